fpu_window_buffer: RTL

FPU_WINDOW_BUFFER -- requirements
Module: fpu_window_buffer

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_win_ctrl.sv | 76 +++++++
 rtl/fpu_window_buffer.sv | 74 +++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fpu_pkg : shared pixel/column types and load-operation encoding  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROWS   = 10;

    typedef logic [DEF_DATA_W-1:0] pixel_t;
    typedef pixel_t [DEF_ROWS-1:0] column_t;

    // How the column registers react to this cycle's input-side event.
    typedef enum logic [1:0] {
        LOAD_NONE  = 2'd0,
        LOAD_SHIFT = 2'd1,
        LOAD_START = 2'd2,
        LOAD_PAD   = 2'd3
    } load_op_t;

    // Columns already valid after a padded band start.
    function automatic int pad_fill(input int kw);
        return kw / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_win_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fpu_win_ctrl : fill count, consumed flag and handshake for the   |
// |                column window                                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fpu_win_ctrl
    import fpu_pkg::*;
#(
    parameter int KW = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     row_start,
    input  logic                     pad_en,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [$clog2(KW+1)-1:0]  fill,
    output load_op_t                 load_op
);

    localparam int                FILL_W = $clog2(KW + 1);
    localparam logic [FILL_W-1:0] C_FULL = FILL_W'(KW);
    localparam logic [FILL_W-1:0] C_PAD  = FILL_W'(pad_fill(KW));

    logic [FILL_W-1:0] r_fill;
    logic              r_consumed;
    logic              w_accept;
    logic              w_consume;

    assign out_valid = (r_fill == C_FULL) && !r_consumed;
    assign in_ready  = !out_valid || out_ready;
    assign fill      = r_fill;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    // Flush drops the column offered alongside it, so no load is issued.
    always_comb begin
        load_op = LOAD_NONE;
        if (w_accept && !flush) begin
            if (!row_start)
                load_op = LOAD_SHIFT;
            else if (pad_en)
                load_op = LOAD_PAD;
            else
                load_op = LOAD_START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill     <= '0;
            r_consumed <= 1'b0;
        end else if (flush) begin
            r_fill     <= '0;
            r_consumed <= 1'b0;
        end else if (w_accept) begin
            r_consumed <= 1'b0;
            if (!row_start) begin
                if (r_fill != C_FULL)
                    r_fill <= r_fill + 1'b1;
            end else if (pad_en) begin
                r_fill <= C_PAD;
            end else begin
                r_fill <= FILL_W'(1);
            end
        end else if (w_consume) begin
            r_consumed <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_window_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fpu_window_buffer : KW-column sliding window over a pixel band   |
// |                     with optional left replicate padding         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fpu_window_buffer
    import fpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int KW     = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ROWS-1:0][DATA_W-1:0]          col_new,
    input  logic                                 row_start,
    input  logic                                 pad_en,
    input  logic                                 flush,
    output logic [KW-1:0][ROWS-1:0][DATA_W-1:0]  win,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(KW+1)-1:0]              fill
);

    // First slot written by a padded band start; everything right of it
    // receives a copy of the leading column.
    localparam int C_PAD_LO = KW - 1 - KW / 2;

    logic [KW-1:0][ROWS-1:0][DATA_W-1:0] r_win;
    load_op_t                            w_load_op;

    fpu_win_ctrl #(
        .KW (KW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .row_start (row_start),
        .pad_en    (pad_en),
        .flush     (flush),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .fill      (fill),
        .load_op   (w_load_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else begin
            case (w_load_op)
                LOAD_SHIFT: begin
                    for (int i = 0; i < KW - 1; i++)
                        r_win[i] <= r_win[i+1];
                    r_win[KW-1] <= col_new;
                end
                LOAD_START: r_win[KW-1] <= col_new;
                LOAD_PAD: begin
                    for (int i = C_PAD_LO; i < KW; i++)
                        r_win[i] <= col_new;
                end
                default: ;
            endcase
        end
    end

    assign win = r_win;

endmodule
`default_nettype wire
